// File: rtl/writeback_ctrl_pkg.sv
// Shared types, select encodings and the kind-to-select mapping for the write-back sequencer.
package wb_pkg;

  typedef enum logic [2:0] {
    KIND_ALU       = 3'd0,
    KIND_LOAD      = 3'd1,
    KIND_LUI       = 3'd2,
    KIND_SLT_FALSE = 3'd3,
    KIND_SLT_TRUE  = 3'd4,
    KIND_SHIFT     = 3'd5,
    KIND_RSVD6     = 3'd6,
    KIND_RSVD7     = 3'd7
  } wb_kind_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MEMWAIT = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_WRITE   = 3'd3,
    ST_ERR     = 3'd4
  } wb_state_t;

  localparam logic [2:0] SEL_ALU   = 3'b000;
  localparam logic [2:0] SEL_MDR   = 3'b001;
  localparam logic [2:0] SEL_LUI   = 3'b010;
  localparam logic [2:0] SEL_ZERO  = 3'b011;
  localparam logic [2:0] SEL_ONE   = 3'b100;
  localparam logic [2:0] SEL_SHIFT = 3'b101;

  // Reserved kinds 6 and 7 fall through to the ALU source.
  function automatic logic [2:0] kind_to_sel(input wb_kind_t kind);
    case (kind)
      KIND_LOAD:      return SEL_MDR;
      KIND_LUI:       return SEL_LUI;
      KIND_SLT_FALSE: return SEL_ZERO;
      KIND_SLT_TRUE:  return SEL_ONE;
      KIND_SHIFT:     return SEL_SHIFT;
      default:        return SEL_ALU;
    endcase
  endfunction

endpackage

// File: rtl/writeback_ctrl_if.sv
// Bundle between the main control FSM / shift unit and the write-back sequencer.
interface writeback_ctrl_if;
  import wb_pkg::*;

  // Handshake: WbReq is taken only at an edge where the sequencer is idle
  // (WbBusy low); there is no ready, a request while busy is dropped, and
  // completion is reported by a single-cycle WbDone (with WbError on timeout).
  logic       WbReq;
  logic [2:0] WbKind;
  logic [4:0] WbDest;
  logic       ShiftDone;
  logic       WbBusy;
  logic       WbDone;
  logic       WbError;
  logic       ShiftStart;
  logic       MDRLoad;
  logic [2:0] MemtoReg;
  logic       RegWrite;
  logic [4:0] WriteReg;
  wb_state_t  dbg_state;

  modport master (
    output WbReq, WbKind, WbDest, ShiftDone,
    input  WbBusy, WbDone, WbError, ShiftStart, MDRLoad,
    input  MemtoReg, RegWrite, WriteReg, dbg_state
  );

  modport slave (
    input  WbReq, WbKind, WbDest, ShiftDone,
    output WbBusy, WbDone, WbError, ShiftStart, MDRLoad,
    output MemtoReg, RegWrite, WriteReg, dbg_state
  );

endinterface

// File: rtl/wb_cycle_counter.sv
// Loadable saturating down-counter with current and next-cycle zero flags.
module wb_cycle_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o,
  output logic         zero_next_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o      = (count_q == '0);
  assign zero_next_o = (count_d == '0);

endmodule

// File: rtl/writeback_ctrl.sv
// Register-file write-back sequencer: waits for memory or the shift unit, then writes for one cycle.
// Optional macro WB_ZERO_GUARD_EN suppresses RegWrite when the destination is register 0.
module writeback_ctrl
  import wb_pkg::*;
#(
  parameter int unsigned MEM_WAIT      = 1,
  parameter int unsigned SHIFT_TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             reset,
  writeback_ctrl_if.slave  wb
);

  // Shared counter must hold both reload values.
  localparam int unsigned CNT_W_SHIFT = $clog2(SHIFT_TIMEOUT);
  localparam int unsigned CNT_W_MEM   = $clog2(MEM_WAIT);
  localparam int unsigned CNT_W       = (CNT_W_SHIFT > CNT_W_MEM) ? CNT_W_SHIFT : CNT_W_MEM;
  localparam logic [CNT_W-1:0] MEM_LOAD   = CNT_W'(MEM_WAIT - 1);
  localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(SHIFT_TIMEOUT - 1);

  wb_state_t        state_q, state_d;
  wb_kind_t         kind_q, kind_d;
  logic [4:0]       dest_q, dest_d;
  logic             cnt_load, cnt_dec, cnt_zero, cnt_zero_next;
  logic [CNT_W-1:0] cnt_load_val;

  logic       busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic       sstart_q, sstart_d, mdr_q, mdr_d, regwrite_q, regwrite_d;
  logic [2:0] sel_q, sel_d;
  logic [4:0] wreg_q, wreg_d;
  logic       in_write;

  wb_cycle_counter #(.W(CNT_W)) u_cnt (
    .clk         (clk),
    .reset       (reset),
    .load_i      (cnt_load),
    .load_val_i  (cnt_load_val),
    .dec_i       (cnt_dec),
    .zero_o      (cnt_zero),
    .zero_next_o (cnt_zero_next)
  );

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    dest_d       = dest_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wb.WbReq) begin
          kind_d = wb_kind_t'(wb.WbKind);
          dest_d = wb.WbDest;
          case (kind_d)
            KIND_LOAD: begin
              state_d      = ST_MEMWAIT;
              cnt_load     = 1'b1;
              cnt_load_val = MEM_LOAD;
            end
            KIND_SHIFT: begin
              state_d      = ST_SHIFT;
              cnt_load     = 1'b1;
              cnt_load_val = SHIFT_LOAD;
            end
            default: state_d = ST_WRITE;
          endcase
        end
      end
      ST_MEMWAIT: begin
        if (cnt_zero) state_d = ST_WRITE;
        else          cnt_dec = 1'b1;
      end
      ST_SHIFT: begin
        // The start cycle ignores ShiftDone; the shift unit cannot have finished yet.
        if (sstart_q)          cnt_dec = 1'b1;
        else if (wb.ShiftDone) state_d = ST_WRITE;
        else if (cnt_zero)     state_d = ST_ERR;
        else                   cnt_dec = 1'b1;
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the cycle they describe.
  always_comb begin
    in_write   = (state_d == ST_WRITE);
    busy_d     = (state_d != ST_IDLE);
    done_d     = in_write || (state_d == ST_ERR);
    error_d    = (state_d == ST_ERR);
    sstart_d   = (state_d == ST_SHIFT) && (state_q == ST_IDLE);
    mdr_d      = (state_d == ST_MEMWAIT) && cnt_zero_next;
    sel_d      = in_write ? kind_to_sel(kind_d) : SEL_ALU;
    wreg_d     = in_write ? dest_d : 5'd0;
`ifdef WB_ZERO_GUARD_EN
    regwrite_d = in_write && (dest_d != 5'd0);
`else
    regwrite_d = in_write;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      kind_q     <= KIND_ALU;
      dest_q     <= 5'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      sstart_q   <= 1'b0;
      mdr_q      <= 1'b0;
      regwrite_q <= 1'b0;
      sel_q      <= SEL_ALU;
      wreg_q     <= 5'd0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      dest_q     <= dest_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      sstart_q   <= sstart_d;
      mdr_q      <= mdr_d;
      regwrite_q <= regwrite_d;
      sel_q      <= sel_d;
      wreg_q     <= wreg_d;
    end
  end

  assign wb.WbBusy     = busy_q;
  assign wb.WbDone     = done_q;
  assign wb.WbError    = error_q;
  assign wb.ShiftStart = sstart_q;
  assign wb.MDRLoad    = mdr_q;
  assign wb.MemtoReg   = sel_q;
  assign wb.RegWrite   = regwrite_q;
  assign wb.WriteReg   = wreg_q;
  assign wb.dbg_state  = state_q;

endmodule
